// File: rtl/pipe_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipelined main-control unit of the 5-stage MIPS
// core: opcode values, ALU control classes, the per-instruction control
// bundle carried down the pipeline, and the all-zero bubble bundle.
// No ports (package).
// ----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    // Opcode field values (instruction[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // ALU control classes; the bundle always holds the widest (3-bit) form
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;

    typedef struct packed {
        logic       we_reg;
        logic       reg_dst;
        logic       alu_src;
        logic [2:0] alu_op;
        logic       link;
        logic       we_dm;
        logic       dm2reg;
        logic       illegal;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t CTRL_BUBBLE = '0;

endpackage : pipe_ctrl_pkg

// File: rtl/pipe_ctrl_decode.sv
// ----------------------------------------------------------------------------
// pipe_ctrl_decode
// Purely combinational opcode -> control-bundle decoder for the ID stage.
// Ports:
//   i_opcode    [OPCODE_W] ID-stage opcode
//   o_ctrl      bundle     decoded control bundle (illegal=1 for unknown ops)
//   o_branch    1          opcode is BEQ
//   o_branch_ne 1          opcode is BNE (extended set only)
//   o_jump      1          opcode is J or JAL
// ----------------------------------------------------------------------------
module pipe_ctrl_decode
    import pipe_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int ALU_OP_W = 3,
    parameter int EXT_IMM  = 1
) (
    input  logic [OPCODE_W-1:0] i_opcode,
    output ctrl_bundle_t        o_ctrl,
    output logic                o_branch,
    output logic                o_branch_ne,
    output logic                o_jump
);

    // The extended set needs 3-bit ALU codes; a narrow ALU field forces the
    // extended opcodes to decode as illegal instead of aliasing onto 00/01/10.
    localparam bit EXT_OK = (EXT_IMM != 0) && (ALU_OP_W >= 3);

    // Opcode decode; every path starts from the bubble so nothing is left X
    always_comb begin
        o_ctrl      = CTRL_BUBBLE;
        o_branch    = 1'b0;
        o_branch_ne = 1'b0;
        o_jump      = 1'b0;
        case (i_opcode)
            OPCODE_W'(OP_RTYPE): begin
                o_ctrl.we_reg  = 1'b1;
                o_ctrl.reg_dst = 1'b1;
                o_ctrl.alu_op  = ALU_FUNCT;
            end
            OPCODE_W'(OP_ADDI): begin
                o_ctrl.we_reg  = 1'b1;
                o_ctrl.alu_src = 1'b1;
                o_ctrl.alu_op  = ALU_ADD;
            end
            OPCODE_W'(OP_BEQ): begin
                o_ctrl.alu_op  = ALU_SUB;
                o_branch       = 1'b1;
            end
            OPCODE_W'(OP_J): begin
                o_jump         = 1'b1;
            end
            OPCODE_W'(OP_JAL): begin
                o_jump         = 1'b1;
                o_ctrl.we_reg  = 1'b1;
                o_ctrl.link    = 1'b1;
                o_ctrl.alu_op  = ALU_ADD;
            end
            OPCODE_W'(OP_SW): begin
                o_ctrl.alu_src = 1'b1;
                o_ctrl.we_dm   = 1'b1;
                o_ctrl.alu_op  = ALU_ADD;
            end
            OPCODE_W'(OP_LW): begin
                o_ctrl.we_reg  = 1'b1;
                o_ctrl.alu_src = 1'b1;
                o_ctrl.dm2reg  = 1'b1;
                o_ctrl.alu_op  = ALU_ADD;
            end
            OPCODE_W'(OP_ANDI), OPCODE_W'(OP_ORI), OPCODE_W'(OP_SLTI): begin
                if (EXT_OK) begin
                    o_ctrl.we_reg  = 1'b1;
                    o_ctrl.alu_src = 1'b1;
                    if (i_opcode == OPCODE_W'(OP_ANDI)) begin
                        o_ctrl.alu_op = ALU_AND;
                    end else if (i_opcode == OPCODE_W'(OP_ORI)) begin
                        o_ctrl.alu_op = ALU_OR;
                    end else begin
                        o_ctrl.alu_op = ALU_SLT;
                    end
                end else begin
                    o_ctrl.illegal = 1'b1;
                end
            end
            OPCODE_W'(OP_BNE): begin
                if (EXT_OK) begin
                    o_ctrl.alu_op = ALU_SUB;
                    o_branch_ne   = 1'b1;
                end else begin
                    o_ctrl.illegal = 1'b1;
                end
            end
            default: begin
                o_ctrl.illegal = 1'b1;
            end
        endcase
    end

endmodule : pipe_ctrl_decode

// File: rtl/pipe_ctrl_unit.sv
// ----------------------------------------------------------------------------
// pipe_ctrl_unit
// Pipelined main control: decodes the ID opcode and carries the control
// bundle through the ID/EX, EX/MEM and MEM/WB control registers.
// Optional feature macro: PIPE_CTRL_LOAD_USE_STALL_EN (internal load-use
// hazard detection; adds rs_d, rt_d, write_reg_e inputs, lu_stall output and
// the REG_ADDR_W parameter).
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   opcode_d, valid_d          ID opcode and its valid flag
//   stall_d, flush_e           bubble into EX / squash instruction entering EX
//   branch_d, branch_ne_d, jump_d   ID-stage combinational branch/jump
//   reg_dst_e, alu_src_e, alu_op_e, link_e, illegal_e   EX-stage controls
//   we_dm_m, dm2reg_m, we_reg_m                         MEM-stage controls
//   we_reg_w, dm2reg_w, link_w                          WB-stage controls
// ----------------------------------------------------------------------------
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int OPCODE_W   = 6,
    parameter int ALU_OP_W   = 3,
`ifdef PIPE_CTRL_LOAD_USE_STALL_EN
    parameter int REG_ADDR_W = 5,
`endif
    parameter int EXT_IMM    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [OPCODE_W-1:0]   opcode_d,
    input  logic                  valid_d,
    input  logic                  stall_d,
    input  logic                  flush_e,
`ifdef PIPE_CTRL_LOAD_USE_STALL_EN
    input  logic [REG_ADDR_W-1:0] rs_d,
    input  logic [REG_ADDR_W-1:0] rt_d,
    input  logic [REG_ADDR_W-1:0] write_reg_e,
    output logic                  lu_stall,
`endif
    output logic                  branch_d,
    output logic                  branch_ne_d,
    output logic                  jump_d,
    output logic                  reg_dst_e,
    output logic                  alu_src_e,
    output logic [ALU_OP_W-1:0]   alu_op_e,
    output logic                  link_e,
    output logic                  illegal_e,
    output logic                  we_dm_m,
    output logic                  dm2reg_m,
    output logic                  we_reg_m,
    output logic                  we_reg_w,
    output logic                  dm2reg_w,
    output logic                  link_w
);

    ctrl_bundle_t w_dec_ctrl;
    logic         w_dec_branch;
    logic         w_dec_branch_ne;
    logic         w_dec_jump;
    logic         w_bubble;

    ctrl_bundle_t r_id_ex;
    logic         r_m_we_dm;
    logic         r_m_dm2reg;
    logic         r_m_we_reg;
    logic         r_m_link;
    logic         r_w_we_reg;
    logic         r_w_dm2reg;
    logic         r_w_link;

    pipe_ctrl_decode #(
        .OPCODE_W (OPCODE_W),
        .ALU_OP_W (ALU_OP_W),
        .EXT_IMM  (EXT_IMM)
    ) u_decode (
        .i_opcode    (opcode_d),
        .o_ctrl      (w_dec_ctrl),
        .o_branch    (w_dec_branch),
        .o_branch_ne (w_dec_branch_ne),
        .o_jump      (w_dec_jump)
    );

    // Redirects only come from a real instruction in ID
    assign branch_d    = w_dec_branch    & valid_d;
    assign branch_ne_d = w_dec_branch_ne & valid_d;
    assign jump_d      = w_dec_jump      & valid_d;

`ifdef PIPE_CTRL_LOAD_USE_STALL_EN
    // A load in EX whose (non-$0) destination is a source of the ID instruction
    assign lu_stall = r_id_ex.dm2reg & r_id_ex.we_reg
                    & (write_reg_e != '0)
                    & ((write_reg_e == rs_d) | (write_reg_e == rt_d))
                    & valid_d;
    assign w_bubble = stall_d | flush_e | ~valid_d | lu_stall;
`else
    assign w_bubble = stall_d | flush_e | ~valid_d;
`endif

    // ID/EX control register: a bubble replaces the decoded bundle when held
    always_ff @(posedge clk) begin
        if (rst) begin
            r_id_ex <= CTRL_BUBBLE;
        end else if (w_bubble) begin
            r_id_ex <= CTRL_BUBBLE;
        end else begin
            r_id_ex <= w_dec_ctrl;
        end
    end

    // EX/MEM control register: advances every cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_we_dm  <= 1'b0;
            r_m_dm2reg <= 1'b0;
            r_m_we_reg <= 1'b0;
            r_m_link   <= 1'b0;
        end else begin
            r_m_we_dm  <= r_id_ex.we_dm;
            r_m_dm2reg <= r_id_ex.dm2reg;
            r_m_we_reg <= r_id_ex.we_reg;
            r_m_link   <= r_id_ex.link;
        end
    end

    // MEM/WB control register: advances every cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_w_we_reg <= 1'b0;
            r_w_dm2reg <= 1'b0;
            r_w_link   <= 1'b0;
        end else begin
            r_w_we_reg <= r_m_we_reg;
            r_w_dm2reg <= r_m_dm2reg;
            r_w_link   <= r_m_link;
        end
    end

    assign reg_dst_e = r_id_ex.reg_dst;
    assign alu_src_e = r_id_ex.alu_src;
    // Narrow ALU field builds keep only the low bits (codes 00/01/10 only)
    assign alu_op_e  = ALU_OP_W'(r_id_ex.alu_op);
    assign link_e    = r_id_ex.link;
    assign illegal_e = r_id_ex.illegal;
    assign we_dm_m   = r_m_we_dm;
    assign dm2reg_m  = r_m_dm2reg;
    assign we_reg_m  = r_m_we_reg;
    assign we_reg_w  = r_w_we_reg;
    assign dm2reg_w  = r_w_dm2reg;
    assign link_w    = r_w_link;

endmodule : pipe_ctrl_unit
